// File: rtl/plot_pkg.sv
// Shared constants and types for the rectangle-fill plot controller.
// Screen geometry, coordinate/colour widths, FSM encoding and clear colour.
package plot_pkg;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COL_W    = 3;

   localparam logic [COL_W-1:0] CLEAR_COLOUR = 3'b000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/plot_rect_ctrl_if.sv
// Command handshake plus pixel-plot port of the rectangle-fill controller.
// master = user/game logic side, slave = the controller.
interface plot_rect_ctrl_if;
   import plot_pkg::*;

   logic             req_valid;
   logic             req_ready;
   logic             req_clear;
   logic [X_W-1:0]   req_x;
   logic [Y_W-1:0]   req_y;
   logic [X_W-1:0]   req_w;
   logic [Y_W-1:0]   req_h;
   logic [COL_W-1:0] req_colour;

   logic [X_W-1:0]   plot_x;
   logic [Y_W-1:0]   plot_y;
   logic [COL_W-1:0] plot_colour;
   logic             plot;
   logic             busy;
   logic             done;

   modport master (
      output req_valid, req_clear, req_x, req_y, req_w, req_h, req_colour,
      input  req_ready, plot_x, plot_y, plot_colour, plot, busy, done
   );

   modport slave (
      input  req_valid, req_clear, req_x, req_y, req_w, req_h, req_colour,
      output req_ready, plot_x, plot_y, plot_colour, plot, busy, done
   );
endinterface

// File: rtl/rect_scan_counter.sv
// Nested raster counter: cx runs 0..w-1, then wraps and bumps cy; size latched on load.
// Exposes the next-cycle count so the owner can register outputs without a bubble.
module rect_scan_counter
   import plot_pkg::*;
(
   input  logic           Clock,
   input  logic           Resetn,
   input  logic           i_load,
   input  logic           i_en,
   input  logic [X_W-1:0] i_w,
   input  logic [Y_W-1:0] i_h,
   output logic [X_W-1:0] o_cx_nxt,
   output logic [Y_W-1:0] o_cy_nxt,
   output logic           o_last
);
   logic [X_W-1:0] r_cx, r_w;
   logic [Y_W-1:0] r_cy, r_h;
   logic           w_col_end;

   assign w_col_end = (r_cx == r_w - 8'd1);
   assign o_last    = w_col_end && (r_cy == r_h - 7'd1);

   always_comb begin
      o_cx_nxt = r_cx;
      o_cy_nxt = r_cy;
      if (i_load) begin
         o_cx_nxt = '0;
         o_cy_nxt = '0;
      end else if (i_en) begin
         if (w_col_end) begin
            o_cx_nxt = '0;
            o_cy_nxt = r_cy + 7'd1;
         end else begin
            o_cx_nxt = r_cx + 8'd1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_cx <= '0;
         r_cy <= '0;
         r_w  <= '0;
         r_h  <= '0;
      end else begin
         r_cx <= o_cx_nxt;
         r_cy <= o_cy_nxt;
         if (i_load) begin
            r_w <= i_w;
            r_h <= i_h;
         end
      end
   end
endmodule

// File: rtl/plot_rect_ctrl.sv
// Rectangle-fill / screen-clear sequencer feeding the 160x120 VGA adapter plot port.
// One pixel per clock, registered outputs; optional clipping via PLOT_RECT_CLIP_EN.
module plot_rect_ctrl
   import plot_pkg::*;
(
   input  logic            Clock,
   input  logic            Resetn,
   plot_rect_ctrl_if.slave bus
);
   state_t           r_state, w_state_nxt;
   logic             w_accept, w_draw, w_last, w_empty, w_in_range, w_plot_d;
   logic [X_W-1:0]   w_x_eff, w_w_eff, r_x0, w_x0_nxt, w_cx_nxt, w_plot_x_d;
   logic [Y_W-1:0]   w_y_eff, w_h_eff, r_y0, w_y0_nxt, w_cy_nxt, w_plot_y_d;
   logic [COL_W-1:0] w_col_eff, r_colour, w_col_nxt;
   logic             r_plot, r_done, r_busy, r_ready;
   logic [X_W-1:0]   r_plot_x;
   logic [Y_W-1:0]   r_plot_y;
   logic [COL_W-1:0] r_plot_colour;

   assign w_accept  = (r_state == IDLE) && bus.req_valid;
   assign w_draw    = (r_state == DRAW);
   assign w_x_eff   = bus.req_clear ? '0 : bus.req_x;
   assign w_y_eff   = bus.req_clear ? '0 : bus.req_y;
   assign w_w_eff   = bus.req_clear ? X_W'(SCREEN_W) : bus.req_w;
   assign w_h_eff   = bus.req_clear ? Y_W'(SCREEN_H) : bus.req_h;
   assign w_col_eff = bus.req_clear ? CLEAR_COLOUR : bus.req_colour;
   assign w_empty   = (w_w_eff == '0) || (w_h_eff == '0);

   // Output registers look one cycle ahead, so use the values the latches will hold next.
   assign w_x0_nxt  = w_accept ? w_x_eff   : r_x0;
   assign w_y0_nxt  = w_accept ? w_y_eff   : r_y0;
   assign w_col_nxt = w_accept ? w_col_eff : r_colour;

   rect_scan_counter u_scan (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .i_load   (w_accept),
      .i_en     (w_draw),
      .i_w      (w_w_eff),
      .i_h      (w_h_eff),
      .o_cx_nxt (w_cx_nxt),
      .o_cy_nxt (w_cy_nxt),
      .o_last   (w_last)
   );

   always_ff @(posedge Clock) begin
      if (!Resetn) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.req_valid) w_state_nxt = w_empty ? DONE : DRAW;
         DRAW:    if (w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

`ifdef PLOT_RECT_CLIP_EN
   logic [X_W:0] w_x_sum;
   logic [Y_W:0] w_y_sum;
   assign w_x_sum = {1'b0, w_x0_nxt} + {1'b0, w_cx_nxt};
   assign w_y_sum = {1'b0, w_y0_nxt} + {1'b0, w_cy_nxt};
`endif

   always_comb begin
`ifdef PLOT_RECT_CLIP_EN
      w_plot_x_d = w_x_sum[X_W-1:0];
      w_plot_y_d = w_y_sum[Y_W-1:0];
      w_in_range = (w_x_sum < 9'(SCREEN_W)) && (w_y_sum < 8'(SCREEN_H));
`else
      w_plot_x_d = w_x0_nxt + w_cx_nxt;
      w_plot_y_d = w_y0_nxt + w_cy_nxt;
      w_in_range = 1'b1;
`endif
      w_plot_d = (w_state_nxt == DRAW) && w_in_range;
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_x0          <= '0;
         r_y0          <= '0;
         r_colour      <= '0;
         r_plot        <= 1'b0;
         r_done        <= 1'b0;
         r_busy        <= 1'b0;
         r_ready       <= 1'b1;
         r_plot_x      <= '0;
         r_plot_y      <= '0;
         r_plot_colour <= '0;
      end else begin
         r_x0     <= w_x0_nxt;
         r_y0     <= w_y0_nxt;
         r_colour <= w_col_nxt;
         r_plot   <= w_plot_d;
         r_done   <= (w_state_nxt == DONE);
         r_busy   <= (w_state_nxt != IDLE);
         r_ready  <= (w_state_nxt == IDLE);
         if (w_state_nxt == DRAW) begin
            r_plot_x      <= w_plot_x_d;
            r_plot_y      <= w_plot_y_d;
            r_plot_colour <= w_col_nxt;
         end
      end
   end

   assign bus.plot        = r_plot;
   assign bus.done        = r_done;
   assign bus.busy        = r_busy;
   assign bus.req_ready   = r_ready;
   assign bus.plot_x      = r_plot_x;
   assign bus.plot_y      = r_plot_y;
   assign bus.plot_colour = r_plot_colour;
endmodule

// File: tb/tb_plot_rect_ctrl.sv
// Directed bench for plot_rect_ctrl: table of rectangle commands plus hand-written
// sequences for reset, back-to-back acceptance and reset during a draw.
module tb_plot_rect_ctrl;
   logic Clock;
   logic Resetn;
   int   checks;
   int   failures;

   plot_rect_ctrl_if bus ();

   plot_rect_ctrl dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .bus    (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      string       name;
      logic        clr;
      logic [7:0]  x;
      logic [6:0]  y;
      logic [7:0]  w;
      logic [6:0]  h;
      logic [2:0]  col;
      int          exp_n;
      logic [14:0] exp_first;
      logic [14:0] exp_last;
   } vec_t;

   vec_t vecs [8];

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int w, h, x0, y0, wh, s, n, errs, k, ex, ey;
      logic [2:0]  col;
      logic [14:0] first, last;
      bit          exp_plot;
      w   = v.clr ? 160 : int'(v.w);
      h   = v.clr ? 120 : int'(v.h);
      x0  = v.clr ? 0 : int'(v.x);
      y0  = v.clr ? 0 : int'(v.y);
      col = v.clr ? 3'b000 : v.col;
      wh  = w * h;
      check({v.name, "_ready_idle"}, 32'(bus.req_ready), 1);
      bus.req_valid  = 1'b1;
      bus.req_clear  = v.clr;
      bus.req_x      = v.x;
      bus.req_y      = v.y;
      bus.req_w      = v.w;
      bus.req_h      = v.h;
      bus.req_colour = v.col;
      tick();
      bus.req_valid  = 1'b0;
      // Scramble inputs while busy: they must be ignored.
      bus.req_clear  = 1'($urandom);
      bus.req_x      = 8'($urandom);
      bus.req_y      = 7'($urandom);
      bus.req_w      = 8'($urandom);
      bus.req_h      = 7'($urandom);
      bus.req_colour = 3'($urandom);
      s = 1; n = 0; errs = 0; first = '0; last = '0;
      while (!bus.done && s <= wh + 2) begin
         exp_plot = 1'b0;
         ex = 0; ey = 0;
         if (s <= wh) begin
            k  = s - 1;
            ex = x0 + (k % w);
            ey = y0 + (k / w);
`ifdef PLOT_RECT_CLIP_EN
            exp_plot = (ex < 160) && (ey < 120);
`else
            exp_plot = 1'b1;
`endif
         end
         if (bus.plot !== exp_plot || bus.req_ready !== 1'b0 || bus.busy !== 1'b1) errs++;
         if (bus.plot === 1'b1) begin
            if (n == 0) first = {bus.plot_x, bus.plot_y};
            last = {bus.plot_x, bus.plot_y};
            n++;
            if (exp_plot && ({bus.plot_x, bus.plot_y} !== {8'(ex), 7'(ey)} ||
                             bus.plot_colour !== col)) errs++;
         end
         tick();
         s++;
      end
      check({v.name, "_done_lat"}, 32'(s), 32'(wh + 1));
      check({v.name, "_plot_at_done"}, 32'(bus.plot), 0);
      check({v.name, "_nplots"}, 32'(n), 32'(v.exp_n));
      check({v.name, "_pixel_errs"}, 32'(errs), 0);
      if (v.exp_n > 0) begin
         check({v.name, "_first"}, 32'(first), 32'(v.exp_first));
         check({v.name, "_last"}, 32'(last), 32'(v.exp_last));
      end
      tick();
      check({v.name, "_ready_after"}, 32'(bus.req_ready), 1);
      check({v.name, "_done_width"}, 32'(bus.done), 0);
      check({v.name, "_busy_after"}, 32'(bus.busy), 0);
   endtask

   initial begin
      int cnt_done, cnt_plot;
      checks = 0;
      failures = 0;
      bus.req_valid = 1'b0; bus.req_clear = 1'b0;
      bus.req_x = '0; bus.req_y = '0; bus.req_w = '0; bus.req_h = '0; bus.req_colour = '0;

      vecs[0] = '{"rect3x2", 1'b0, 8'd10, 7'd20, 8'd3, 7'd2, 3'b100, 6, {8'd10, 7'd20}, {8'd12, 7'd21}};
      vecs[1] = '{"clear", 1'b1, 8'd5, 7'd5, 8'd1, 7'd1, 3'b111, 19200, {8'd0, 7'd0}, {8'd159, 7'd119}};
      vecs[2] = '{"w0", 1'b0, 8'd3, 7'd3, 8'd0, 7'd5, 3'b001, 0, 15'd0, 15'd0};
      vecs[3] = '{"h0", 1'b0, 8'd3, 7'd3, 8'd5, 7'd0, 3'b001, 0, 15'd0, 15'd0};
`ifdef PLOT_RECT_CLIP_EN
      vecs[4] = '{"edge158", 1'b0, 8'd158, 7'd0, 8'd4, 7'd1, 3'b010, 2, {8'd158, 7'd0}, {8'd159, 7'd0}};
      vecs[5] = '{"corner", 1'b0, 8'd255, 7'd127, 8'd1, 7'd1, 3'b011, 0, 15'd0, 15'd0};
      vecs[6] = '{"offscr", 1'b0, 8'd200, 7'd100, 8'd2, 7'd3, 3'b001, 0, 15'd0, 15'd0};
      vecs[7] = '{"max", 1'b0, 8'd0, 7'd0, 8'd255, 7'd127, 3'b111, 19200, {8'd0, 7'd0}, {8'd159, 7'd119}};
`else
      vecs[4] = '{"edge158", 1'b0, 8'd158, 7'd0, 8'd4, 7'd1, 3'b010, 4, {8'd158, 7'd0}, {8'd161, 7'd0}};
      vecs[5] = '{"corner", 1'b0, 8'd255, 7'd127, 8'd1, 7'd1, 3'b011, 1, {8'd255, 7'd127}, {8'd255, 7'd127}};
      vecs[6] = '{"offscr", 1'b0, 8'd200, 7'd100, 8'd2, 7'd3, 3'b001, 6, {8'd200, 7'd100}, {8'd201, 7'd102}};
      vecs[7] = '{"max", 1'b0, 8'd0, 7'd0, 8'd255, 7'd127, 3'b111, 32385, {8'd0, 7'd0}, {8'd254, 7'd126}};
`endif

      Resetn = 1'b0;
      tick();
      tick();
      Resetn = 1'b1;
      tick();
      check("rst_ready", 32'(bus.req_ready), 1);
      check("rst_plot", 32'(bus.plot), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_xyc", 32'({bus.plot_x, bus.plot_y, bus.plot_colour}), 0);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Back-to-back: valid held high, 2x1 at (1,1) then (50,2).
      bus.req_valid = 1'b1; bus.req_clear = 1'b0;
      bus.req_x = 8'd1; bus.req_y = 7'd1; bus.req_w = 8'd2; bus.req_h = 7'd1; bus.req_colour = 3'b101;
      tick();
      check("b2b_s1_x", 32'(bus.plot_x), 1);
      bus.req_x = 8'd50; bus.req_y = 7'd2; bus.req_colour = 3'b110;
      tick();
      check("b2b_s2_x", 32'(bus.plot_x), 2);
      check("b2b_s2_col", 32'(bus.plot_colour), 32'(3'b101));
      tick();
      check("b2b_s3_done", 32'(bus.done), 1);
      tick();
      check("b2b_s4_idle", 32'({bus.req_ready, bus.plot, bus.done}), 32'(3'b100));
      tick();
      bus.req_valid = 1'b0;
      check("b2b_s5_plot", 32'(bus.plot), 1);
      check("b2b_s5_xy", 32'({bus.plot_x, bus.plot_y}), 32'({8'd50, 7'd2}));
      for (int i = 0; i < 6; i++) tick();
      check("b2b_idle", 32'(bus.req_ready), 1);

      // Reset asserted while the 5th pixel of a 10x10 is on the port.
      bus.req_valid = 1'b1; bus.req_x = 8'd0; bus.req_y = 7'd0;
      bus.req_w = 8'd10; bus.req_h = 7'd10; bus.req_colour = 3'b001;
      tick();
      bus.req_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("mid_5th_x", 32'({bus.plot, bus.plot_x}), 32'({1'b1, 8'd4}));
      Resetn = 1'b0;
      tick();
      Resetn = 1'b1;
      check("mid_plot", 32'(bus.plot), 0);
      check("mid_ready", 32'(bus.req_ready), 1);
      check("mid_busy", 32'(bus.busy), 0);
      cnt_done = 0; cnt_plot = 0;
      for (int i = 0; i < 120; i++) begin
         tick();
         if (bus.done === 1'b1) cnt_done++;
         if (bus.plot === 1'b1) cnt_plot++;
      end
      check("mid_no_done", 32'(cnt_done), 0);
      check("mid_no_plot", 32'(cnt_plot), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/plot_rect_ctrl.md
Name: plot_rect_ctrl

Overview:
Rectangle-fill sequencer that drives the plot port (x, y, colour, plot) of the 160x120 VGA adapter.
- Accepts one command at a time through a valid/ready handshake: a filled rectangle, or a full-screen clear.
- Walks the rectangle in raster order and emits one pixel write per clock.
- Sits between user/game logic and the adapter, replacing manual KEY-driven single-pixel plotting.

Parameters:
SCREEN_W, 160, horizontal resolution in pixels; legal x is 0..SCREEN_W-1
SCREEN_H, 120, vertical resolution in pixels; legal y is 0..SCREEN_H-1
CLEAR_COLOUR, 3'b000, colour used by clear commands

Ports:
Clock  input  1  system clock (50 MHz)
Resetn  input  1  synchronous active-low reset
req_valid  input  1  command present
req_ready  output  1  controller can accept a command (high only in IDLE)
req_clear  input  1  1 = clear whole screen; rectangle fields ignored
req_x  input  8  rectangle origin x
req_y  input  7  rectangle origin y
req_w  input  8  rectangle width in pixels, 0..255
req_h  input  7  rectangle height in pixels, 0..127
req_colour  input  3  RGB fill colour
plot_x  output  8  pixel x to adapter
plot_y  output  7  pixel y to adapter
plot_colour  output  3  pixel colour to adapter
plot  output  1  pixel write strobe to adapter
busy  output  1  high in DRAW and DONE
done  output  1  one-cycle pulse when a command completes

Behaviour:
- Reset (Resetn low at posedge Clock): synchronous, active-low, clock Clock.
  - Next state IDLE.
  - plot=0, done=0, busy=0, req_ready=1, plot_x=0, plot_y=0, plot_colour=0.
  - Reset mid-DRAW abandons the command: no further plots, no done pulse.
- All outputs are registered.
- FSM states: IDLE, DRAW, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch origin, size and colour.
  - For a clear command, latch origin (0,0), size SCREEN_W x SCREEN_H and CLEAR_COLOUR.
  - Reset the column counter cx and row counter cy to 0.
  - Go to DRAW, or to DONE if the latched w==0 or h==0.
- DRAW:
  - Each cycle: plot=1, plot_x=x0+cx (8-bit, mod 256), plot_y=y0+cy (7-bit, mod 128), plot_colour=latched colour.
  - Order: cx increments each cycle; at cx==w-1, cx returns to 0 and cy increments.
  - At cx==w-1 and cy==h-1, the FSM goes to DONE.
- Latency:
  - First plot is visible the cycle after the accepting edge.
  - Exactly w*h consecutive plot cycles (19200 for a clear).
  - done pulses the cycle after the last plot.
- DONE:
  - plot=0, done=1 for exactly one cycle; then IDLE.
  - A new command is accepted at the earliest on the cycle after done.
- Counter widths: cx is 8 bits and cy is 7 bits. Max sizes 255/127 must count without overflow.
- req_* inputs are sampled only on acceptance. Changes while busy are ignored.
- req_valid held high continuously gives back-to-back commands with one DONE cycle and one IDLE cycle between them.

Optional Feature:
Macro: PLOT_RECT_CLIP_EN.
- Defined:
  - Add x0+cx and y0+cy in 9/8 bits without wrap.
  - Pixels with x>=SCREEN_W or y>=SCREEN_H have plot forced to 0 for that cycle.
  - Sequencing and cycle count are unchanged (w*h cycles).
- Undefined:
  - Coordinates wrap mod 256/128 and are always strobed.
  - Out-of-range addresses are left to the adapter, which ignores them.

Decomposition:
- Package plot_pkg holds:
  - Screen constants SCREEN_W=160 and SCREEN_H=120.
  - Coordinate widths X_W=8 and Y_W=7; colour width 3.
  - FSM state enum {IDLE, DRAW, DONE}.
  - CLEAR_COLOUR default.
- One natural sub-module: rect_scan_counter, the nested cx/cy counter with load, enable and last-pixel flag.
- The FSM and output registers stay in the top level.

Test Plan:
- Reset with Resetn=0 for 2 cycles, then release -> req_ready=1, plot=0, done=0, busy=0, coordinates 0.
- Rectangle x=10, y=20, w=3, h=2, colour=3'b100 -> 6 consecutive plots (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), colour 100; done pulses on the 7th cycle after accept.
- Clear command -> 19200 consecutive plots at colour 000, ending at (159,119); done one cycle later.
- w=0, h=5 -> no plot; done pulses 1 cycle after accept; req_ready returns high the cycle after that.
- Rectangle x=158, w=4, y=0, h=1 -> without the macro: x=158,159,160,161 all strobed. With PLOT_RECT_CLIP_EN: plot high only for 158 and 159; done still comes after 4 cycles.
- Resetn asserted on the 5th plot of a 10x10 rectangle -> plot=0 next cycle, no done, req_ready=1.
